// File: rtl/citadel_glitch_pkg.sv
// Shared state encoding and default parameter values for the glitch response controller.
package citadel_glitch_pkg;

  typedef enum logic [2:0] {
    ST_ARMED    = 3'd0,
    ST_RESPOND  = 3'd1,
    ST_COOLDOWN = 3'd2,
    ST_LOCKED   = 3'd3
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_FILTER_LEN         = 3;
  localparam int unsigned DEF_RESET_PULSE_CYCLES = 16;
  localparam int unsigned DEF_COOLDOWN_CYCLES    = 64;
  localparam int unsigned DEF_MAX_STRIKES        = 3;
  localparam int unsigned DEF_CNT_W              = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/glitch_sync.sv
// Flop-chain synchronizer for the asynchronous detector level, with synchronous clear.
(* keep_hierarchy = "yes" *)
module glitch_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/glitch_response_ctrl.sv
// Turns qualified glitch events into timed reset pulses, cooldown and strike lockout.
// Build option GLITCH_STICKY_LOCK_EN: LOCKED can only be left through rst.
//
// state    | meaning
// ARMED    | filtering det_s, host clears accepted here
// RESPOND  | SYS_RESET asserted for RESET_PULSE_CYCLES
// COOLDOWN | detector ignored for COOLDOWN_CYCLES
// LOCKED   | strike limit reached, LOCKOUT and SYS_RESET held
module glitch_response_ctrl
  import citadel_glitch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN         = DEF_FILTER_LEN,
  parameter int unsigned RESET_PULSE_CYCLES = DEF_RESET_PULSE_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES    = DEF_COOLDOWN_CYCLES,
  parameter int unsigned MAX_STRIKES        = DEF_MAX_STRIKES,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             GLITCH_DETECTED,
  input  logic             CLEAR_REQ,
  output logic             CLEAR_ACK,
  output logic             SYS_RESET,
  output logic             LOCKOUT,
  output logic [CNT_W-1:0] GLITCH_COUNT,
  output logic [2:0]       STATE
);

  localparam int unsigned TMR_W  = $clog2(max_u(RESET_PULSE_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned STRK_W = $clog2(MAX_STRIKES + 1);

  logic det_s;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [FILT_W-1:0]  filt_q, filt_d;
  logic [STRK_W-1:0]  strikes_q, strikes_d;
  logic [CNT_W-1:0]   gcount_q, gcount_d;
  logic               ack_q, ack_d;
  logic               sys_reset_q, sys_reset_d;
  logic               lockout_q, lockout_d;
  logic               clr_done_q, clr_done_d;
  logic               hit;
  logic               clr_ok;
  logic               clr_accept;

  glitch_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .clr_i (rst),
    .d_i   (GLITCH_DETECTED),
    .q_o   (det_s)
  );

  // A request already acknowledged must drop low before another can be accepted.
  assign clr_ok = CLEAR_REQ & ~clr_done_q;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    filt_d     = '0;
    strikes_d  = strikes_q;
    gcount_d   = gcount_q;
    ack_d      = 1'b0;
    clr_done_d = clr_done_q & CLEAR_REQ;
    hit        = 1'b0;
    clr_accept = 1'b0;

    case (state_q)
      ST_ARMED: begin
        if (det_s) begin
          if (filt_q == FILT_W'(FILTER_LEN - 1)) begin
            hit = 1'b1;
          end else begin
            filt_d = filt_q + FILT_W'(1);
          end
        end
        if (hit) begin
          if (gcount_q != {CNT_W{1'b1}}) begin
            gcount_d = gcount_q + CNT_W'(1);
          end
          strikes_d = strikes_q + STRK_W'(1);
          if (strikes_d >= STRK_W'(MAX_STRIKES)) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_RESPOND;
            tmr_d   = TMR_W'(RESET_PULSE_CYCLES - 1);
          end
        end else if (clr_ok) begin
          strikes_d  = '0;
          clr_accept = 1'b1;
        end
      end
      ST_RESPOND: begin
        if (tmr_q == '0) begin
          state_d = ST_COOLDOWN;
          tmr_d   = TMR_W'(COOLDOWN_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COOLDOWN: begin
        if (tmr_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_LOCKED: begin
`ifndef GLITCH_STICKY_LOCK_EN
        if (clr_ok) begin
          state_d    = ST_ARMED;
          strikes_d  = '0;
          clr_accept = 1'b1;
        end
`endif
      end
      default: state_d = ST_ARMED;
    endcase

    if (clr_accept) begin
      ack_d      = 1'b1;
      clr_done_d = 1'b1;
    end

    sys_reset_d = (state_d == ST_RESPOND) || (state_d == ST_LOCKED);
    lockout_d   = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARMED;
      tmr_q       <= '0;
      filt_q      <= '0;
      strikes_q   <= '0;
      gcount_q    <= '0;
      ack_q       <= 1'b0;
      sys_reset_q <= 1'b0;
      lockout_q   <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      filt_q      <= filt_d;
      strikes_q   <= strikes_d;
      gcount_q    <= gcount_d;
      ack_q       <= ack_d;
      sys_reset_q <= sys_reset_d;
      lockout_q   <= lockout_d;
      clr_done_q  <= clr_done_d;
    end
  end

  assign CLEAR_ACK    = ack_q;
  assign SYS_RESET    = sys_reset_q;
  assign LOCKOUT      = lockout_q;
  assign GLITCH_COUNT = gcount_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_glitch_response_ctrl.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor matches them.
module tb_glitch_response_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, gd, req;
  logic       ack, sysr, lock;
  logic [7:0] gcnt;
  logic [2:0] st;

  logic       gd_b;
  logic       req_b;
  logic       ack_b, sysr_b, lock_b;
  logic [1:0] gcnt_b;
  logic [2:0] st_b;

  glitch_response_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .GLITCH_DETECTED (gd),
    .CLEAR_REQ       (req),
    .CLEAR_ACK       (ack),
    .SYS_RESET       (sysr),
    .LOCKOUT         (lock),
    .GLITCH_COUNT    (gcnt),
    .STATE           (st)
  );

  glitch_response_ctrl #(
    .SYNC_STAGES        (2),
    .FILTER_LEN         (1),
    .RESET_PULSE_CYCLES (2),
    .COOLDOWN_CYCLES    (2),
    .MAX_STRIKES        (7),
    .CNT_W              (2)
  ) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .GLITCH_DETECTED (gd_b),
    .CLEAR_REQ       (req_b),
    .CLEAR_ACK       (ack_b),
    .SYS_RESET       (sysr_b),
    .LOCKOUT         (lock_b),
    .GLITCH_COUNT    (gcnt_b),
    .STATE           (st_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // kinds: 0 SYS_RESET rise, 1 SYS_RESET fall, 2 LOCKOUT rise, 3 LOCKOUT fall, 4 CLEAR_ACK
  typedef struct {
    int kind;
    int cyc;
    int cnt;
    int st;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int k, input int c, input int n, input int s);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = n;
    e.st   = s;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int k);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: kind %0d at cyc %0d cnt %0d state %0d, expected none",
               k, cyc, gcnt, st);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc || e.cnt != int'(gcnt) || e.st != int'(st)) begin
        failures++;
        $display("FAIL event: got kind %0d cyc %0d cnt %0d state %0d, expected kind %0d cyc %0d cnt %0d state %0d",
                 k, cyc, gcnt, st, e.kind, e.cyc, e.cnt, e.st);
      end
    end
  endtask

  logic p_sysr = 1'b0;
  logic p_lock = 1'b0;

  always @(negedge clk) begin
    if (!p_sysr && sysr) observe(0);
    if (p_sysr && !sysr) observe(1);
    if (!p_lock && lock) observe(2);
    if (p_lock && !lock) observe(3);
    if (ack) observe(4);
    p_sysr <= sysr;
    p_lock <= lock;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (!ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ack) begin
      failures++;
      $display("FAIL %s: CLEAR_ACK not seen, got 0 expected 1 within 200 cycles", name);
    end
  endtask

  int   t;
  int   base;
  int   rises;
  int   n;
  logic prev_b;

  initial begin
    rst   = 1'b1;
    gd    = 1'b0;
    req   = 1'b0;
    gd_b  = 1'b0;
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sys_reset", sysr, 0);
    check("reset_lockout", lock, 0);
    check("reset_clear_ack", ack, 0);
    check("reset_count", gcnt, 0);
    check("reset_state", st, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // two-cycle detector blip must be filtered out
    t  = cyc;
    gd = 1'b1;
    repeat (2) @(negedge clk);
    gd = 1'b0;
    repeat (20) @(negedge clk);
    check("blip_sys_reset", sysr, 0);
    check("blip_count", gcnt, 0);

    // single strike, detector kept high into cooldown
    t  = cyc;
    gd = 1'b1;
    push(0, t + 5, 1, 1);
    push(1, t + 21, 1, 2);
    wait_until(t + 40);
    gd = 1'b0;
    wait_until(t + 50);
    check("cooldown_state", st, 2);
    wait_until(t + 100);
    check("rearmed_state", st, 0);
    check("strike1_count", gcnt, 1);

    // second strike with a clear request raised during RESPOND
    t  = cyc;
    gd = 1'b1;
    push(0, t + 5, 2, 1);
    push(1, t + 21, 2, 2);
    push(4, t + 86, 2, 0);
    wait_until(t + 8);
    req = 1'b1;
    wait_until(t + 10);
    gd = 1'b0;
    wait_ack("pending_clear_ack");
    @(negedge clk);
    req = 1'b0;
    wait_until(t + 100);
    check("after_clear_count", gcnt, 2);

    // strikes were cleared, so three more qualified events are needed to lock
    t  = cyc;
    gd = 1'b1;
    push(0, t + 5, 3, 1);
    push(1, t + 21, 3, 2);
    push(0, t + 88, 4, 1);
    push(1, t + 104, 4, 2);
    push(0, t + 171, 5, 3);
    push(2, t + 171, 5, 3);
    wait_until(t + 180);
    gd = 1'b0;
    wait_until(t + 190);
    check("locked_lockout", lock, 1);
    check("locked_sys_reset", sysr, 1);
    check("locked_state", st, 3);
    check("locked_count", gcnt, 5);

`ifdef GLITCH_STICKY_LOCK_EN
    req = 1'b1;
    repeat (20) @(negedge clk);
    check("sticky_state", st, 3);
    check("sticky_lockout", lock, 1);
    req = 1'b0;
    repeat (2) @(negedge clk);
    t   = cyc;
    rst = 1'b1;
    push(1, t + 1, 0, 0);
    push(3, t + 1, 0, 0);
    @(negedge clk);
    rst  = 1'b0;
    base = 0;
`else
    t   = cyc;
    req = 1'b1;
    push(1, t + 1, 5, 0);
    push(3, t + 1, 5, 0);
    push(4, t + 1, 5, 0);
    wait_ack("unlock_ack");
    req = 1'b0;
    check("unlock_state", st, 0);
    base = 5;
`endif
    repeat (5) @(negedge clk);

    // reset in the middle of RESPOND
    t  = cyc;
    gd = 1'b1;
    push(0, t + 5, base + 1, 1);
    push(1, t + 11, 0, 0);
    wait_until(t + 10);
    rst = 1'b1;
    gd  = 1'b0;
    @(negedge clk);
    check("midrst_sys_reset", sysr, 0);
    check("midrst_state", st, 0);
    check("midrst_count", gcnt, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    // narrow counter saturation on the second instance
    gd_b   = 1'b1;
    rises  = 0;
    n      = 0;
    prev_b = 1'b0;
    while (rises < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (sysr_b && !prev_b) begin
        rises++;
        if (rises == 2) check("sat_count_at_2", gcnt_b, 2);
      end
      prev_b = sysr_b;
    end
    check("sat_rises", rises, 5);
    gd_b = 1'b0;
    repeat (20) @(negedge clk);
    check("sat_count", gcnt_b, 3);
    check("sat_no_lockout", lock_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
